// File: rtl/matmul_share_arbiter.sv
// Round-robin arbiter that shares one matrix-multiply engine among N requesters.
// Latches the winner's operands, pulses start, and returns done/timeout as per-requester ack/err.
module matmul_share_arbiter #(
    parameter  int N       = 4,
    parameter  int A_W     = 1152,
    parameter  int B_W     = 1152,
    parameter  int TIMEOUT = 4096,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [9*N-1:0]     dims_in,
    input  logic [A_W*N-1:0]   a_in,
    input  logic [B_W*N-1:0]   b_in,
    output logic               mm_start,
    output logic [2:0]         mm_rowsA,
    output logic [2:0]         mm_colsA,
    output logic [2:0]         mm_colsB,
    output logic [A_W-1:0]     mm_Ain,
    output logic [B_W-1:0]     mm_Bin,
    input  logic               mm_done,
    output logic [N-1:0]       ack,
    output logic [N-1:0]       err,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_start;
    logic               r_busy;
    logic [2:0]         r_rowsA;
    logic [2:0]         r_colsA;
    logic [2:0]         r_colsB;
    logic [A_W-1:0]     r_ain;
    logic [B_W-1:0]     r_bin;
    logic [N-1:0]       r_ack;
    logic [N-1:0]       r_err;

    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_cand;
    logic               w_found;
    logic [8:0]         w_winDims;

    // Scan upward from the requester after the last one served, wrapping round.
    always_comb begin
        w_win   = r_last;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_winDims = dims_in[9*w_win +: 9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_next = WAIT;
            WAIT:    if (mm_done || (r_cnt == CNT_LAST)) w_next = RELEASE;
            RELEASE: if (!req[r_grant]) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Done is only honoured in WAIT, so a level-style done lingering into RELEASE cannot re-ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_rowsA <= '0;
            r_colsA <= '0;
            r_colsB <= '0;
            r_ain   <= '0;
            r_bin   <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_grant <= '0;
            r_last  <= IDX_LAST;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
            r_busy  <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant <= w_win;
                        {r_rowsA, r_colsA, r_colsB} <= w_winDims;
                        r_ain   <= a_in[A_W*w_win +: A_W];
                        r_bin   <= b_in[B_W*w_win +: B_W];
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (mm_done) begin
                        r_ack[r_grant] <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err[r_grant] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_last <= r_grant;
                end
                default: begin
                end
            endcase
        end
    end

    assign mm_start  = r_start;
    assign mm_rowsA  = r_rowsA;
    assign mm_colsA  = r_colsA;
    assign mm_colsB  = r_colsB;
    assign mm_Ain    = r_ain;
    assign mm_Bin    = r_bin;
    assign ack       = r_ack;
    assign err       = r_err;
    assign busy      = r_busy;
    assign grant_idx = r_grant;

endmodule

// File: tb/tb_matmul_share_arbiter.sv
// Scoreboard bench for matmul_share_arbiter: random requesters and engine, a cycle-level
// reference model pushes expected grants/responses, a monitor pops and compares them.
module tb_matmul_share_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int BW = 64;
    localparam int TO = 16;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [9*N-1:0]    dims_in;
    logic [AW*N-1:0]   a_in;
    logic [BW*N-1:0]   b_in;
    logic              mm_start;
    logic [2:0]        mm_rowsA;
    logic [2:0]        mm_colsA;
    logic [2:0]        mm_colsB;
    logic [AW-1:0]     mm_Ain;
    logic [BW-1:0]     mm_Bin;
    logic              mm_done;
    logic [N-1:0]      ack;
    logic [N-1:0]      err;
    logic              busy;
    logic [1:0]        grant_idx;

    matmul_share_arbiter #(.N(N), .A_W(AW), .B_W(BW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .dims_in(dims_in), .a_in(a_in), .b_in(b_in),
        .mm_start(mm_start), .mm_rowsA(mm_rowsA), .mm_colsA(mm_colsA), .mm_colsB(mm_colsB),
        .mm_Ain(mm_Ain), .mm_Bin(mm_Bin), .mm_done(mm_done), .ack(ack), .err(err),
        .busy(busy), .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; int idx; logic [8:0] dims; logic [63:0] a; logic [63:0] b; } startExp_t;
    typedef struct { int cyc; logic [N-1:0] ackV; logic [N-1:0] errV; } respExp_t;
    typedef enum { M_FREE, M_BUSY, M_REL } mstate_t;

    startExp_t   startQ[$];
    respExp_t    respQ[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          inReset;
    bit          mBusyExp;
    mstate_t     mState;
    int          mLast;
    int          mGrant;
    int          mElapsed;
    logic [N-1:0] rPend;
    logic [N-1:0] gotResp;
    int          holdCnt [N];
    int          engDelay;
    bit          engLevel;
    int          tail;
    bit          heldValid;
    logic [63:0] heldA;
    logic [63:0] heldB;
    logic [8:0]  heldDims;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic resetModel();
        mState    = M_FREE;
        mLast     = N - 1;
        mGrant    = 0;
        mElapsed  = 0;
        mBusyExp  = 1'b0;
        rPend     = '0;
        gotResp   = '0;
        engDelay  = -1;
        engLevel  = 1'b0;
        tail      = 0;
        heldValid = 1'b0;
        for (int i = 0; i < N; i++) holdCnt[i] = 0;
        startQ.delete();
        respQ.delete();
    endtask

    // Round-robin rule: first requesting index after the last served one, with wrap.
    function automatic int pickWinner(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // One negedge: requesters, engine, then predict what the next rising edge produces.
    task automatic applyStimulus(input logic [N-1:0] raiseMask, input bit allowRandom);
        bit doneNow;
        int j;
        int w;
        for (int i = 0; i < N; i++) begin
            if (rPend[i]) begin
                if (gotResp[i]) begin
                    if (holdCnt[i] == 0) begin
                        rPend[i]   = 1'b0;
                        gotResp[i] = 1'b0;
                        req[i]     = 1'b0;
                    end else begin
                        holdCnt[i]--;
                    end
                end
            end else if (raiseMask[i] || (allowRandom && $urandom_range(0, 5) == 0)) begin
                rPend[i] = 1'b1;
                req[i]   = 1'b1;
                dims_in[9*i +: 9] = raiseMask[i] ? 9'b110110110 : 9'($urandom);
                a_in[AW*i +: AW]  = {$urandom, $urandom};
                b_in[BW*i +: BW]  = {$urandom, $urandom};
            end
        end

        doneNow = 1'b0;
        if (tail > 0) begin
            doneNow = 1'b1;
            tail--;
        end
        if (engDelay > 0) begin
            engDelay--;
            if (engDelay == 0) begin
                doneNow = 1'b1;
                if (!engLevel) engDelay = -1;
            end
        end else if (engDelay == 0) begin
            doneNow = 1'b1;
        end
        mm_done = doneNow;

        case (mState)
            M_FREE: begin
                w = pickWinner(req, mLast);
                if (w >= 0) begin
                    startQ.push_back('{cyc + 1, w, dims_in[9*w +: 9], a_in[AW*w +: AW], b_in[BW*w +: BW]});
                    mGrant   = w;
                    mElapsed = 0;
                    mState   = M_BUSY;
                    case ($urandom_range(0, 9))
                        0:       j = -1;
                        1:       j = TO - 1;
                        2:       j = TO - 2;
                        default: j = $urandom_range(0, 6);
                    endcase
                    engDelay = (j < 0) ? -1 : j + 1;
                    engLevel = 1'($urandom_range(0, 1));
                end
            end
            M_BUSY: begin
                mElapsed++;
                if (mm_done || mElapsed == TO) begin
                    respQ.push_back('{cyc + 1, mm_done ? N'(1) << mGrant : '0,
                                      mm_done ? '0 : N'(1) << mGrant});
                    if (engLevel && mm_done) tail = 2;
                    engDelay        = -1;
                    gotResp[mGrant] = 1'b1;
                    holdCnt[mGrant] = $urandom_range(0, 3);
                    mState          = M_REL;
                end
            end
            default: begin
                mLast = mGrant;
                if (!req[mGrant]) mState = M_FREE;
            end
        endcase
        mBusyExp = (mState != M_FREE);
    endtask

    // Monitor: pops expectations whose cycle has arrived, otherwise expects quiet outputs.
    initial begin
        startExp_t se;
        respExp_t  re;
        logic [N-1:0] expAck;
        logic [N-1:0] expErr;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!inReset) begin
                checkOutput("busy", 64'(busy), 64'(mBusyExp));
                if (startQ.size() > 0 && startQ[0].cyc == cyc) begin
                    se = startQ.pop_front();
                    checkOutput("mm_start", 64'(mm_start), 64'd1);
                    checkOutput("grant_idx", 64'(grant_idx), 64'(se.idx));
                    checkOutput("dims", 64'({mm_rowsA, mm_colsA, mm_colsB}), 64'(se.dims));
                    checkOutput("mm_Ain", mm_Ain, se.a);
                    checkOutput("mm_Bin", mm_Bin, se.b);
                    heldA     = se.a;
                    heldB     = se.b;
                    heldDims  = se.dims;
                    heldValid = 1'b1;
                end else begin
                    checkOutput("mm_start_quiet", 64'(mm_start), 64'd0);
                    if (heldValid && busy) begin
                        checkOutput("Ain_hold", mm_Ain, heldA);
                        checkOutput("Bin_hold", mm_Bin, heldB);
                        checkOutput("dims_hold", 64'({mm_rowsA, mm_colsA, mm_colsB}), 64'(heldDims));
                    end
                end
                if (!busy) heldValid = 1'b0;
                expAck = '0;
                expErr = '0;
                if (respQ.size() > 0 && respQ[0].cyc == cyc) begin
                    re     = respQ.pop_front();
                    expAck = re.ackV;
                    expErr = re.errV;
                end
                checkOutput("ack", 64'(ack), 64'(expAck));
                checkOutput("err", 64'(err), 64'(expErr));
            end
        end
    end

    initial begin
        bit found;
        inReset = 1'b1;
        rst     = 1'b1;
        req     = '0;
        dims_in = '0;
        a_in    = '0;
        b_in    = '0;
        mm_done = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("rst_mm_start", 64'(mm_start), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_ack", 64'(ack), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_grant_idx", 64'(grant_idx), 64'd0);
        checkOutput("rst_mm_Ain", mm_Ain, 64'd0);

        rst     = 1'b0;
        inReset = 1'b0;
        applyStimulus(4'b0001, 1'b0);
        repeat (40) begin @(negedge clk); applyStimulus('0, 1'b0); end

        @(negedge clk);
        applyStimulus(4'b1111, 1'b0);
        repeat (150) begin @(negedge clk); applyStimulus('0, 1'b0); end

        repeat (2500) begin @(negedge clk); applyStimulus('0, 1'b1); end

        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            applyStimulus('0, 1'b1);
            if (mState == M_BUSY && mElapsed >= 1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_wait", 64'(found), 64'd1);
        #2;
        rst     = 1'b1;
        inReset = 1'b1;
        #1;
        checkOutput("async_busy", 64'(busy), 64'd0);
        checkOutput("async_mm_start", 64'(mm_start), 64'd0);
        checkOutput("async_ack", 64'(ack), 64'd0);
        checkOutput("async_err", 64'(err), 64'd0);
        resetModel();
        req     = '0;
        mm_done = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        inReset = 1'b0;
        applyStimulus(4'b0100, 1'b0);
        repeat (40) begin @(negedge clk); applyStimulus('0, 1'b0); end

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            applyStimulus('0, 1'b0);
            if (mState == M_FREE && rPend == '0) break;
        end
        @(posedge clk);
        #2;
        checkOutput("starts_pending", 64'(startQ.size()), 64'd0);
        checkOutput("resps_pending", 64'(respQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
